// File: rtl/agc_controller.sv
// rtl/agc_controller.sv - frame-rate automatic gain control loop with hold-off, settle, fast step-down and manual override

module agc_controller #(
    parameter int DATA_W    = 10,
    parameter int GAIN_W    = 4,
    parameter int GAIN_MAX  = 15,
    parameter int GAIN_INIT = 0,
    parameter int LOW_TH    = 700,
    parameter int HIGH_TH   = 1000,
    parameter int SAT_TH    = 1023,
    parameter int HOLD_N    = 2,
    parameter int SETTLE_N  = 1,
    parameter int FAST_STEP = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              update,
    input  logic [DATA_W-1:0] data_in,
    input  logic              mode_manual,
    input  logic [GAIN_W-1:0] manual_gain,
    input  logic              freeze,
    output logic [GAIN_W-1:0] gain,
    output logic              gain_changed,
    output logic              saturated,
    output logic              at_min,
    output logic              at_max
);

    localparam logic [DATA_W-1:0] LOW   = LOW_TH[DATA_W-1:0];
    localparam logic [DATA_W-1:0] HIGH  = HIGH_TH[DATA_W-1:0];
    localparam logic [DATA_W-1:0] SAT   = SAT_TH[DATA_W-1:0];
    localparam logic [GAIN_W-1:0] GMAX  = GAIN_MAX[GAIN_W-1:0];
    localparam logic [GAIN_W-1:0] GINIT = GAIN_INIT[GAIN_W-1:0];
    localparam logic [GAIN_W-1:0] ONE   = 1;
    localparam logic [GAIN_W:0]   FAST  = FAST_STEP[GAIN_W:0];
    localparam logic [3:0]        HOLD  = HOLD_N[3:0];
    localparam logic [3:0]        SETL  = SETTLE_N[3:0];

    typedef enum logic [1:0] {TRACK, SETTLE, MANUAL} state_t;

    state_t            state, state_nxt;
    logic [GAIN_W-1:0] gain_nxt;
    logic [GAIN_W:0]   gain_ext;
    logic [3:0]        low_cnt, low_nxt, high_cnt, high_nxt, settle_cnt, settle_nxt;
    logic              sat_nxt;

    assign gain_ext = {1'b0, gain};

    always_comb begin
        state_nxt  = state;
        gain_nxt   = gain;
        low_nxt    = low_cnt;
        high_nxt   = high_cnt;
        settle_nxt = settle_cnt;
        sat_nxt    = saturated;
        if (mode_manual) begin
            state_nxt  = MANUAL;
            low_nxt    = 4'd0;
            high_nxt   = 4'd0;
            settle_nxt = 4'd0;
            gain_nxt   = (manual_gain > GMAX) ? GMAX : manual_gain;
        end else begin
            case (state)
                MANUAL: begin
                    if (SETL == 4'd0) begin
                        state_nxt = TRACK;
                    end else begin
                        state_nxt  = SETTLE;
                        settle_nxt = SETL;
                    end
                end
                SETTLE: begin
                    // frames seen while settling are discarded, only counted
                    if (update && !freeze) begin
                        if (settle_cnt <= 4'd1) begin
                            settle_nxt = 4'd0;
                            state_nxt  = TRACK;
                        end else begin
                            settle_nxt = settle_cnt - 4'd1;
                        end
                    end
                end
                TRACK: begin
                    if (update && !freeze) begin
                        if (data_in >= SAT) begin
                            gain_nxt = (gain_ext > FAST) ? gain - FAST[GAIN_W-1:0] : '0;
                            low_nxt  = 4'd0;
                            high_nxt = 4'd0;
                            sat_nxt  = 1'b1;
                        end else begin
                            sat_nxt = 1'b0;
                            if (data_in > HIGH) begin
                                low_nxt = 4'd0;
                                if (high_cnt + 4'd1 >= HOLD) begin
                                    high_nxt = 4'd0;
                                    if (gain != '0) gain_nxt = gain - ONE;
                                end else begin
                                    high_nxt = high_cnt + 4'd1;
                                end
                            end else if (data_in < LOW) begin
                                high_nxt = 4'd0;
                                if (low_cnt + 4'd1 >= HOLD) begin
                                    low_nxt = 4'd0;
                                    if (gain < GMAX) gain_nxt = gain + ONE;
                                end else begin
                                    low_nxt = low_cnt + 4'd1;
                                end
                            end else begin
                                low_nxt  = 4'd0;
                                high_nxt = 4'd0;
                            end
                        end
                        // a step clipped at a limit leaves gain equal, so no settle
                        if (gain_nxt != gain && SETL != 4'd0) begin
                            state_nxt  = SETTLE;
                            settle_nxt = SETL;
                        end
                    end
                end
                default: state_nxt = TRACK;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= TRACK;
            gain         <= GINIT;
            low_cnt      <= 4'd0;
            high_cnt     <= 4'd0;
            settle_cnt   <= 4'd0;
            gain_changed <= 1'b0;
            saturated    <= 1'b0;
            at_min       <= (GINIT == '0);
            at_max       <= (GINIT == GMAX);
        end else begin
            state        <= state_nxt;
            gain         <= gain_nxt;
            low_cnt      <= low_nxt;
            high_cnt     <= high_nxt;
            settle_cnt   <= settle_nxt;
            gain_changed <= (gain_nxt != gain);
            saturated    <= sat_nxt;
            at_min       <= (gain_nxt == '0);
            at_max       <= (gain_nxt == GMAX);
        end
    end

endmodule

// File: tb/tb_agc_controller.sv
// tb/tb_agc_controller.sv - directed self-checking bench for agc_controller

module tb_agc_controller;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       update = 1'b0;
    logic [9:0] data_in = '0;
    logic       mode_manual = 1'b0;
    logic [3:0] manual_gain = '0;
    logic       freeze = 1'b0;
    logic [3:0] gain;
    logic       gain_changed, saturated, at_min, at_max;

    int checks = 0;
    int failures = 0;

    agc_controller dut (
        .clk_in(clk_in), .rst_in(rst_in), .update(update), .data_in(data_in),
        .mode_manual(mode_manual), .manual_gain(manual_gain), .freeze(freeze),
        .gain(gain), .gain_changed(gain_changed), .saturated(saturated),
        .at_min(at_min), .at_max(at_max)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        @(posedge clk_in);
        #1;
    endtask

    task automatic frame(input int d);
        @(negedge clk_in);
        update  = 1'b1;
        data_in = d[9:0];
        @(posedge clk_in);
        #1;
        update = 1'b0;
    endtask

    task automatic manual_set(input int g);
        @(negedge clk_in);
        mode_manual = 1'b1;
        manual_gain = g[3:0];
        @(posedge clk_in);
        #1;
    endtask

    task automatic manual_release();
        @(negedge clk_in);
        mode_manual = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        // reset
        tick(); tick();
        @(negedge clk_in); rst_in = 1'b0;
        tick();
        chk("rst_gain", gain, 0);
        chk("rst_at_min", at_min, 1);
        chk("rst_at_max", at_max, 0);
        chk("rst_changed", gain_changed, 0);
        chk("rst_sat", saturated, 0);

        // hold-off step up
        frame(500);
        chk("hold1_gain", gain, 0);
        chk("hold1_changed", gain_changed, 0);
        frame(500);
        chk("hold2_gain", gain, 1);
        chk("hold2_changed", gain_changed, 1);
        chk("hold2_at_min", at_min, 0);
        tick();
        chk("pulse_width", gain_changed, 0);
        frame(500);
        chk("settle_ignored", gain, 1);
        frame(500);
        chk("after_settle1", gain, 1);
        frame(500);
        chk("after_settle2", gain, 2);

        // saturation
        manual_set(6);
        chk("man6_gain", gain, 6);
        chk("man6_changed", gain_changed, 1);
        manual_release();
        frame(850);
        frame(1023);
        chk("sat1_gain", gain, 2);
        chk("sat1_flag", saturated, 1);
        chk("sat1_changed", gain_changed, 1);
        frame(1023);
        chk("sat_settle_gain", gain, 2);
        chk("sat_settle_flag", saturated, 1);
        frame(1023);
        chk("sat2_gain", gain, 0);
        chk("sat2_at_min", at_min, 1);
        frame(850);
        chk("settle_sat_hold", saturated, 1);
        frame(1023);
        chk("sat3_gain", gain, 0);
        chk("sat3_changed", gain_changed, 0);

        // hysteresis reset
        manual_set(5);
        manual_release();
        frame(850);
        frame(1010);
        chk("hyst_sat_clear", saturated, 0);
        frame(850);
        frame(1010);
        chk("hyst_gain", gain, 5);
        frame(1010);
        chk("hyst_step", gain, 4);

        // limit at GAIN_MAX
        manual_set(15);
        chk("max_at_max", at_max, 1);
        manual_release();
        frame(850);
        frame(500);
        frame(500);
        chk("limit_gain", gain, 15);
        chk("limit_changed", gain_changed, 0);
        frame(1010);
        frame(1010);
        chk("limit_no_settle", gain, 14);

        // manual, freeze
        manual_set(9);
        chk("man9_gain", gain, 9);
        chk("man9_changed", gain_changed, 1);
        tick();
        chk("man9_hold_changed", gain_changed, 0);
        manual_release();
        frame(500);
        chk("release_ignored", gain, 9);
        @(negedge clk_in); freeze = 1'b1;
        for (int i = 0; i < 10; i++) frame(500);
        chk("freeze_gain", gain, 9);
        @(negedge clk_in); freeze = 1'b0;
        frame(500);
        frame(500);
        chk("unfreeze_gain", gain, 10);

        // update coincident with manual rise: manual wins
        @(negedge clk_in);
        mode_manual = 1'b1;
        manual_gain = 4'd10;
        update      = 1'b1;
        data_in     = 10'd1023;
        @(posedge clk_in);
        #1;
        update = 1'b0;
        chk("coinc_gain", gain, 10);
        chk("coinc_changed", gain_changed, 0);
        chk("coinc_sat", saturated, 0);
        manual_release();

        // reset mid-settle
        @(negedge clk_in); rst_in = 1'b1;
        @(posedge clk_in); #1;
        chk("midrst_gain", gain, 0);
        chk("midrst_at_min", at_min, 1);
        @(negedge clk_in); rst_in = 1'b0;
        frame(500);
        frame(500);
        chk("midrst_track", gain, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
